// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback write-port arbiter.
//  REG_ADDR_W / REG_DATA_W : register-file address and data widths
//  REG_ZERO                : architectural zero register, never written
//  wb_req_t                : one buffered writeback request {rd, data}
package wb_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned REG_DATA_W = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [REG_DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/wb_result_fifo.sv
// Small FIFO buffering MDU writeback requests.
//  clk, rst      : clock (posedge), asynchronous active-low reset
//  push_i        : enqueue push_req_i (ignored when full)
//  pop_i         : dequeue head_o (ignored when empty)
//  head_o        : oldest entry
//  full_o/empty_o: occupancy flags, from the registered count
//  ent_valid_o   : per-slot occupancy mask
//  ent_rd_o      : per-slot destination register, for hazard compares
module wb_result_fifo
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                push_i,
    input  wb_req_t                             push_req_i,
    input  logic                                pop_i,
    output wb_req_t                             head_o,
    output logic                                full_o,
    output logic                                empty_o,
    output logic [DEPTH-1:0]                    ent_valid_o,
    output logic [DEPTH-1:0][REG_ADDR_W-1:0]    ent_rd_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    wb_req_t         mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic            do_push;
    logic            do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign head_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_req_i;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CW'(1);
            end else if (!do_push && do_pop) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    // A slot is live when its distance from the read pointer (mod DEPTH) is below the count.
    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        logic [PW-1:0] off;
        assign off            = PW'(i) - rd_ptr_q;
        assign ent_valid_o[i] = (CW'(off) < count_q);
        assign ent_rd_o[i]    = mem_q[i].rd;
    end

endmodule

// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter at the writeback end.
// Merges the single-cycle ALU result with buffered MDU results, reports buffered destinations
// to the hazard unit and forces an MDU slot when the ALU has starved the buffer too long.
//  clk, rst                  : clock (posedge), asynchronous active-low reset
//  alu_valid/alu_rd/alu_data : ALU result, no backpressure
//  mdu_valid/mdu_ready       : MDU result handshake; mdu_rd/mdu_data carried with it
//  rf_we/rf_waddr/rf_wdata   : registered write port (regfile samples on negedge)
//  q_rs/q_rt, q_*_pend       : hazard queries against buffered destinations
//  wb_stall                  : one-cycle request for upstream to hold alu_valid low
//  protocol_err              : sticky flag, alu_valid seen during wb_stall
module wb_write_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [REG_DATA_W-1:0] alu_data,
    input  logic                  mdu_valid,
    output logic                  mdu_ready,
    input  logic [REG_ADDR_W-1:0] mdu_rd,
    input  logic [REG_DATA_W-1:0] mdu_data,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [REG_DATA_W-1:0] rf_wdata,
    input  logic [REG_ADDR_W-1:0] q_rs,
    input  logic [REG_ADDR_W-1:0] q_rt,
    output logic                  q_rs_pend,
    output logic                  q_rt_pend,
    output logic                  wb_stall,
    output logic                  protocol_err
);

    localparam int unsigned SW = $clog2(STARVE_MAX + 1);

    wb_req_t                         head;
    wb_req_t                         push_req;
    logic                            fifo_full;
    logic                            fifo_empty;
    logic [DEPTH-1:0]                ent_valid;
    logic [DEPTH-1:0][REG_ADDR_W-1:0] ent_rd;
    logic                            push;
    logic                            pop;
    logic                            take_alu;
    logic [SW-1:0]                   starve_q;
    logic [SW-1:0]                   starve_d;
    logic                            stall_d;

    // Handshake completes for rd==0, but the request is discarded rather than buffered.
    assign mdu_ready     = ~fifo_full;
    assign push          = mdu_valid & ~fifo_full & (mdu_rd != REG_ZERO);
    assign push_req.rd   = mdu_rd;
    assign push_req.data = mdu_data;

    wb_result_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_req_i  (push_req),
        .pop_i       (pop),
        .head_o      (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .ent_valid_o (ent_valid),
        .ent_rd_o    (ent_rd)
    );

    // Slot select; an ALU result arriving during wb_stall is never eligible.
    always_comb begin
        pop      = 1'b0;
        take_alu = 1'b0;
        if (wb_stall && !fifo_empty) begin
            pop = 1'b1;
        end else if (!wb_stall && alu_valid && (alu_rd != REG_ZERO)) begin
            take_alu = 1'b1;
        end else if (!fifo_empty) begin
            pop = 1'b1;
        end
    end

    always_comb begin
        starve_d = starve_q;
        stall_d  = 1'b0;
        if (pop || fifo_empty) begin
            starve_d = '0;
        end else if (take_alu) begin
            if (starve_q == SW'(STARVE_MAX - 1)) begin
                starve_d = '0;
                stall_d  = 1'b1;
            end else begin
                starve_d = starve_q + SW'(1);
            end
        end
    end

    // Head being popped this cycle still counts as pending until rf_we shows it.
    always_comb begin
        q_rs_pend = 1'b0;
        q_rt_pend = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i] && (ent_rd[i] == q_rs) && (q_rs != REG_ZERO)) q_rs_pend = 1'b1;
            if (ent_valid[i] && (ent_rd[i] == q_rt) && (q_rt != REG_ZERO)) q_rt_pend = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_we        <= 1'b0;
            rf_waddr     <= '0;
            rf_wdata     <= '0;
            starve_q     <= '0;
            wb_stall     <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            if (pop) begin
                rf_we    <= 1'b1;
                rf_waddr <= head.rd;
                rf_wdata <= head.data;
            end else if (take_alu) begin
                rf_we    <= 1'b1;
                rf_waddr <= alu_rd;
                rf_wdata <= alu_data;
            end else begin
                rf_we <= 1'b0;
            end
            starve_q <= starve_d;
            wb_stall <= stall_d;
            if (alu_valid && wb_stall) begin
                protocol_err <= 1'b1;
            end
        end
    end

endmodule
